freq_meter: RTL
===============

Name: freq_meter

Overview:
- Measuring counterpart of the clock divider: samples a slow, asynchronous square wave (e.g. a divided clk_out or an external pin) on the 27 MHz system clock.
- Reports the input's period and high time in system-clock cycles.
- Used for on-board self-check of divider outputs and for board bring-up; results are handed off via a valid/ready handshake.

Parameters:
- CNT_W, 24, width of period/high counters (covers periods up to about 0.62 s at 27 MHz).
- SYNC_STAGES, 2, flip-flops in the input synchronizer (minimum 2).
- TIMEOUT_CYC, 27_000_000, cycles without a required edge before timeout (1 s).

Ports:
- clk  input  1  system clock, 27 MHz
- rst_n  input  1  asynchronous active-low reset
- sig_in  input  1  asynchronous signal under measurement
- start  input  1  one-cycle pulse; begins one measurement when idle
- period_cyc  output  CNT_W  cycles between two consecutive rising edges
- high_cyc  output  CNT_W  cycles sig was high within that period
- res_valid  output  1  result available; held until accepted
- res_ready  input  1  consumer accepts the result when res_valid && res_ready
- timeout  output  1  set together with res_valid when the measurement aborted
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low, asynchronous): synchronizer flip-flops = 0, state = IDLE, counters = 0, all outputs 0.
- Synchronizer and edge detection:
  - sig_in passes SYNC_STAGES flip-flops to give sig_s, plus one history flip-flop.
  - rise = sig_s & ~prev; fall = ~sig_s & prev. Both are single-cycle pulses.
  - Synchronizer latency affects both edges equally, so it does not bias the measured counts.
- State IDLE: start = 1 goes to ARM and clears both counters and the timer. start is ignored in all other states.
- State ARM (waiting for the first rising edge):
  - rise goes to MEAS with period counter = 1 and high counter = 1.
  - If the timer reaches TIMEOUT_CYC - 1 with no rise, go to DONE with timeout = 1.
- State MEAS:
  - Every cycle: period counter +1. High counter +1 when sig_s = 1.
  - The timer restarts on every rise or fall; if it reaches TIMEOUT_CYC - 1, go to DONE with timeout = 1.
  - On the next rise: latch period_cyc = period counter and high_cyc = high counter (the values before that cycle's increment), then go to DONE with timeout = 0.
- Counter saturation: counters stop at all-ones and do not wrap. A saturated period counter forces timeout = 1 at completion.
- State DONE:
  - res_valid = 1. period_cyc, high_cyc and timeout stay stable while res_valid is high.
  - The handshake completes when res_valid && res_ready; the next cycle is IDLE with res_valid = 0.
  - timeout stays valid until the handshake completes, then clears.
  - If res_ready is already high on entry to DONE, res_valid is high for exactly one cycle.
- Result outputs on timeout: period_cyc = 0 and high_cyc = 0.
- Latency: res_valid rises 1 cycle after the synchronized second rising edge, i.e. SYNC_STAGES + 2 cycles after that edge on sig_in.
- Simultaneous events: a rise in the same cycle the timer expires counts as a completed measurement (edge wins).
- Reset during a measurement returns to IDLE immediately and discards any partial result.
- Constant high or constant low input leads to timeout after TIMEOUT_CYC cycles.

Decomposition:
- Package freq_meter_pkg:
  - State enum typedef with states IDLE, ARM, MEAS, DONE.
  - Localparam SYS_CLK_HZ = 27_000_000.
- Sub-module sync_edge_det, parameter STAGES, ports clk, rst_n, d, q, rise, fall. It is reusable for pushbutton inputs.
- The FSM, counters and timer live in freq_meter.

Test Plan:
- Reset behaviour: assert rst_n low mid-MEAS; outputs read 0 and busy = 0 immediately, and the FSM returns to IDLE.
- 1 kHz, 50 % duty (period 27000 cycles, high 13500), start pulse → period_cyc = 27000, high_cyc = 13500, timeout = 0, res_valid within 2 periods plus 4 cycles.
- 25 % duty, period 1000 cycles → period_cyc = 1000, high_cyc = 250. Hold res_ready = 0 for 50 cycles; outputs must stay stable and res_valid must stay high.
- Constant-low sig_in with TIMEOUT_CYC overridden to 5000 → timeout = 1, res_valid = 1 at 5000 cycles after start, period_cyc = 0.
- Stream of 10 start/accept pairs on the divided clock from freq_div → every result equals the divider's nominal period; res_ready high on entry gives a 1-cycle res_valid.
- Rise coinciding with timer expiry (TIMEOUT_CYC = 1000, period 1000) → completed result with timeout = 0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency/period meter.
package freq_meter_pkg;

    localparam int SYS_CLK_HZ = 27_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles.
// state | meaning
// IDLE  | waiting for start
// ARM   | waiting for the first rising edge
// MEAS  | counting until the next rising edge
// DONE  | result presented, waiting for res_ready
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = SYS_CLK_HZ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic [CNT_W-1:0] period_cyc,
    output logic [CNT_W-1:0] high_cyc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             timeout,
    output logic             busy
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic sig_s, rise, fall;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sig_in),
        .q    (sig_s),
        .rise (rise),
        .fall (fall)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  per_res_q, per_res_d;
    logic [CNT_W-1:0]  high_res_q, high_res_d;
    logic              tout_q, tout_d;

    // Timer is a down-counter: loaded with TIMEOUT_CYC-1, expires at zero.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        high_d     = high_q;
        tmr_d      = tmr_q;
        per_res_d  = per_res_q;
        high_res_d = high_res_q;
        tout_d     = tout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ARM;
                    period_d = '0;
                    high_d   = '0;
                    tmr_d    = TMR_LOAD;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d  = MEAS;
                    period_d = CNT_W'(1);
                    high_d   = CNT_W'(1);
                    tmr_d    = TMR_LOAD;
                end else if (tmr_q == '0) begin
                    state_d    = DONE;
                    tout_d     = 1'b1;
                    per_res_d  = '0;
                    high_res_d = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            MEAS: begin
                period_d = (period_q == CNT_MAX) ? period_q : period_q + 1'b1;
                if (sig_s && high_q != CNT_MAX) begin
                    high_d = high_q + 1'b1;
                end
                // A rise wins over a simultaneous timer expiry.
                if (rise) begin
                    state_d = DONE;
                    if (period_q == CNT_MAX) begin
                        tout_d     = 1'b1;
                        per_res_d  = '0;
                        high_res_d = '0;
                    end else begin
                        tout_d     = 1'b0;
                        per_res_d  = period_q;
                        high_res_d = high_q;
                    end
                end else if (tmr_q == '0) begin
                    state_d    = DONE;
                    tout_d     = 1'b1;
                    per_res_d  = '0;
                    high_res_d = '0;
                end else if (fall) begin
                    tmr_d = TMR_LOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d    = IDLE;
                    tout_d     = 1'b0;
                    per_res_d  = '0;
                    high_res_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            period_q   <= '0;
            high_q     <= '0;
            tmr_q      <= '0;
            per_res_q  <= '0;
            high_res_q <= '0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            high_q     <= high_d;
            tmr_q      <= tmr_d;
            per_res_q  <= per_res_d;
            high_res_q <= high_res_d;
            tout_q     <= tout_d;
        end
    end

    assign period_cyc = per_res_q;
    assign high_cyc   = high_res_q;
    assign timeout    = tout_q;
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule
